// File: rtl/dunc16_mem_responder.sv
// Purpose: word-addressed 16-bit RAM serving DUNC16 CPU fetch/LDA/STA over a REQ/ACK
//          handshake, plus a loader write port usable while the CPU is idle.
// Latency: request sampled in IDLE at edge 0; ACK/RDATA visible after edge WAIT_STATES+1.
// Backpressure: BUSY while an access is in flight; loader stalls (LD_READY=0) unless IDLE with no REQ.
// Ports:
//   CLK, RESET            clock, asynchronous active-low reset
//   REQ, WE, ADDR, WDATA  CPU request, latched when sampled in IDLE
//   RDATA, ACK, BUSY      registered read data, one-cycle completion pulse, in-flight flag
//   LD_VALID/ADDR/DATA    loader write strobe, address, data
//   LD_READY              loader write accepted this cycle
module dunc16_mem_responder #(
    parameter int AW          = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQ,
    input  logic          WE,
    input  logic [AW-1:0] ADDR,
    input  logic [15:0]   WDATA,
    output logic [15:0]   RDATA,
    output logic          ACK,
    output logic          BUSY,
    input  logic          LD_VALID,
    input  logic [AW-1:0] LD_ADDR,
    input  logic [15:0]   LD_DATA,
    output logic          LD_READY
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    wait_cnt;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [15:0]   req_wdata;
    logic          take_req;
    logic          ld_write;
    logic          cpu_access;

    // Contents deliberately survive reset so a loaded program is kept.
    logic [15:0]   mem [0:(1<<AW)-1];

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (REQ) state_nxt = (WS != 4'd0) ? S_WAIT : S_ACCESS;
            // Counter is loaded with WAIT_STATES, so leaving at 1 gives exactly that many WAIT cycles.
            S_WAIT:   if (wait_cnt == 4'd1) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        BUSY       = (state != S_IDLE);
        // CPU wins arbitration: loader is only accepted in IDLE with no pending REQ.
        LD_READY   = (state == S_IDLE) && !REQ;
        take_req   = (state == S_IDLE) && REQ;
        ld_write   = LD_READY && LD_VALID;
        cpu_access = (state == S_ACCESS);
    end

    // Request latches, wait counter, response registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= 16'h0000;
            wait_cnt  <= 4'd0;
            RDATA     <= 16'h0000;
            ACK       <= 1'b0;
        end else begin
            if (take_req) begin
                req_we    <= WE;
                req_addr  <= ADDR;
                req_wdata <= WDATA;
                wait_cnt  <= WS;
            end else if (state == S_WAIT) begin
                wait_cnt  <= wait_cnt - 4'd1;
            end
            // ACK is high only during RESP, the cycle after ACCESS.
            ACK <= cpu_access;
            if (cpu_access && !req_we) begin
                RDATA <= mem[req_addr];
            end
        end
    end

    // RAM write port: CPU write in ACCESS, loader write in IDLE (never both).
    always_ff @(posedge CLK) begin
        if (cpu_access && req_we) begin
            mem[req_addr] <= req_wdata;
        end else if (ld_write) begin
            mem[LD_ADDR] <= LD_DATA;
        end
    end

endmodule

// File: tb/tb_dunc16_mem_responder.sv
`timescale 1ns/1ps
module tb_dunc16_mem_responder;

    localparam int N = 3;

    function automatic int ws(input int i);
        return (i == 0) ? 0 : (i == 1) ? 3 : 4;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req      [N];
    logic        we       [N];
    logic [7:0]  addr     [N];
    logic [15:0] wdata    [N];
    logic [15:0] rdata    [N];
    logic        ack      [N];
    logic        busy     [N];
    logic        ld_valid [N];
    logic [7:0]  ld_addr  [N];
    logic [15:0] ld_data  [N];
    logic        ld_ready [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        dunc16_mem_responder #(
            .AW(8),
            .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 3 : 4)
        ) u_dut (
            .CLK(clk),
            .RESET(rst_n),
            .REQ(req[g]),
            .WE(we[g]),
            .ADDR(addr[g]),
            .WDATA(wdata[g]),
            .RDATA(rdata[g]),
            .ACK(ack[g]),
            .BUSY(busy[g]),
            .LD_VALID(ld_valid[g]),
            .LD_ADDR(ld_addr[g]),
            .LD_DATA(ld_data[g]),
            .LD_READY(ld_ready[g])
        );
    end

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          inst;
        int          cyc;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q [$];
    logic [15:0] model_mem [N][256];
    logic [15:0] last_rd   [N];

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every ACK consumes one expected response.
    always @(negedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (ack[j] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ack: inst %0d cycle %0d, expected no ACK", j, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ack_inst", j, e.inst);
                    check("ack_cycle", cyc, e.cyc);
                    check("rdata", int'(rdata[j]), int'(e.data));
                end
            end
        end
    end

    // Called at a falling edge; the request is sampled on the next rising edge.
    task automatic drive_req(input int i, input logic w, input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        req[i]   = 1'b1;
        we[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
        e.inst = i;
        e.cyc  = cyc + 1 + ws(i) + 1;
        if (w) begin
            e.data = last_rd[i];
            model_mem[i][a] = d;
        end else begin
            e.data = model_mem[i][a];
            last_rd[i] = e.data;
        end
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int i, output int nbusy);
        nbusy = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (busy[i]) nbusy++;
            if (ack[i]) return;
            if (busy[i]) begin
                // Inputs must be ignored while an access is in flight.
                addr[i]  = 8'($urandom);
                wdata[i] = 16'($urandom);
                we[i]    = 1'($urandom);
            end
        end
        n_cmp++;
        n_fail++;
        $display("FAIL ack_timeout: inst %0d got no ACK, expected one within 40 cycles", i);
    endtask

    task automatic cpu_op(input int i, input logic w, input logic [7:0] a, input logic [15:0] d);
        int nb;
        drive_req(i, w, a, d);
        wait_ack(i, nb);
        req[i] = 1'b0;
        check("busy_cycles", nb, ws(i) + 2);
        @(negedge clk);
        check("busy_after", int'(busy[i]), 0);
    endtask

    task automatic ld_write(input int i, input logic [7:0] a, input logic [15:0] d);
        int t;
        t = 0;
        ld_valid[i] = 1'b1;
        ld_addr[i]  = a;
        ld_data[i]  = d;
        #1;
        while (!ld_ready[i] && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!ld_ready[i]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ld_timeout: inst %0d LD_READY stayed 0, expected 1", i);
        end
        @(negedge clk);
        ld_valid[i] = 1'b0;
        model_mem[i][a] = d;
    endtask

    initial begin
        int nb;
        int e0;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 8'h00; wdata[i] = 16'h0000;
            ld_valid[i] = 1'b0; ld_addr[i] = 8'h00; ld_data[i] = 16'h0000;
            last_rd[i] = 16'h0000;
        end

        // Reset hold and release
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check("rst_rdata", int'(rdata[i]), 0);
            check("rst_ack", int'(ack[i]), 0);
            check("rst_busy", int'(busy[i]), 0);
            check("rst_ld_ready", int'(ld_ready[i]), 1);
        end

        // Fill every RAM through the loader so the model knows all contents
        @(negedge clk);
        for (int a = 0; a < 256; a++) begin
            for (int i = 0; i < N; i++) begin
                ld_valid[i] = 1'b1;
                ld_addr[i]  = 8'(a);
                ld_data[i]  = 16'($urandom);
                model_mem[i][a] = ld_data[i];
            end
            @(negedge clk);
        end
        for (int i = 0; i < N; i++) ld_valid[i] = 1'b0;
        @(negedge clk);

        // Loader write then CPU read, no wait states
        ld_write(0, 8'h05, 16'h1234);
        cpu_op(0, 1'b0, 8'h05, 16'h0000);

        // Write then read, three wait states
        cpu_op(1, 1'b1, 8'h10, 16'hA5A5);
        cpu_op(1, 1'b0, 8'h10, 16'h0000);

        // Arbitration: CPU read and loader write to the same word in the same cycle
        ld_valid[0] = 1'b1;
        ld_addr[0]  = 8'h33;
        ld_data[0]  = 16'hBEEF;
        drive_req(0, 1'b0, 8'h33, 16'h0000);
        #1;
        check("ld_ready_arb", int'(ld_ready[0]), 0);
        wait_ack(0, nb);
        req[0] = 1'b0;
        check("ld_ready_resp", int'(ld_ready[0]), 0);
        @(negedge clk);
        check("ld_ready_idle", int'(ld_ready[0]), 1);
        @(negedge clk);
        ld_valid[0] = 1'b0;
        model_mem[0][8'h33] = 16'hBEEF;
        cpu_op(0, 1'b0, 8'h33, 16'h0000);

        // Back-to-back reads of words 0,1,2 with REQ held high
        e0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            while (cyc != e0 + 3 * k - 1) @(negedge clk);
            drive_req(0, 1'b0, 8'(k), 16'h0000);
        end
        while (cyc != e0 + 7) @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);

        // Reset pulsed during WAIT aborts the write
        cpu_op(2, 1'b1, 8'h20, 16'h1111);
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 8'h20; wdata[2] = 16'hFFFF;
        @(negedge clk);
        req[2] = 1'b0;
        check("wait_busy", int'(busy[2]), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy[2]), 0);
        check("abort_ack", int'(ack[2]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) last_rd[i] = 16'h0000;
        repeat (8) @(negedge clk);
        check("abort_idle", int'(busy[2]), 0);
        cpu_op(2, 1'b0, 8'h20, 16'h0000);

        // Randomized mix of loader writes, CPU writes and CPU reads
        for (int i = 0; i < N; i++) begin
            for (int n = 0; n < 25; n++) begin
                int          op;
                logic [7:0]  a;
                logic [15:0] d;
                op = int'($urandom_range(0, 2));
                a  = 8'($urandom);
                d  = 16'($urandom);
                case (op)
                    0:       ld_write(i, a, d);
                    1:       cpu_op(i, 1'b1, a, d);
                    default: cpu_op(i, 1'b0, a, 16'h0000);
                endcase
            end
        end

        repeat (5) @(negedge clk);
        check("pending_responses", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
